axi_lite_responder: RTL and testbench

AXI_LITE_RESPONDER -- requirements
Module: axi_lite_responder

---
 rtl/axi_lite_responder.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_responder.sv
// AXI4-Lite responder over a DEPTH x 32-bit register file.
// Independent read and write channels, with a privileged upper window.
module axi_lite_responder #(
  parameter int DEPTH     = 256,
  parameter int PRIV_BASE = 192
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        awvalid,
  output logic        awready,
  input  logic [11:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [11:0] araddr,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = 1 << IW;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  r_state_t    r_state;
  w_state_t    w_state;
  logic [31:0] mem [0:NW-1];

  logic        aw_held;
  logic        w_held;
  logic [9:0]  aw_addr;
  logic [2:0]  aw_prot;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [1:0]  ar_resp;
  logic [1:0]  w_resp;

  // Slave-select bits and unused prot bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{araddr[11:10], awaddr[11:10],
                         arprot[2:1], awprot[2:1]};

  function automatic logic [1:0] decode(
    input logic [9:0] addr,
    input logic [2:0] prot
  );
    if (addr[1:0] != 2'b00)
      return SLVERR;
    if (int'(addr[9:2]) >= DEPTH)
      return DECERR;
    if (int'(addr[9:2]) >= PRIV_BASE && !prot[0])
      return SLVERR;
    return OKAY;
  endfunction

  assign ar_resp = decode(araddr[9:0], arprot);
  assign w_resp  = decode(aw_addr, aw_prot);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_state <= R_DATA;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rresp   <= ar_resp;
            rdata   <= (ar_resp == OKAY) ?
                       mem[araddr[2 +: IW]] : '0;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      aw_prot <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      for (int i = 0; i < NW; i++)
        mem[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            if (w_resp == OKAY) begin
              for (int k = 0; k < 4; k++)
                if (w_strb[k])
                  mem[aw_addr[2 +: IW]][8*k +: 8] <=
                    w_data[8*k +: 8];
            end
            w_state <= W_RESP;
            bvalid  <= 1'b1;
            bresp   <= w_resp;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end else begin
            if (awvalid && awready) begin
              aw_held <= 1'b1;
              aw_addr <= awaddr[9:0];
              aw_prot <= awprot;
              awready <= 1'b0;
            end
            if (wvalid && wready) begin
              w_held <= 1'b1;
              w_data <= wdata;
              w_strb <= wstrb;
              wready <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_responder.sv
// Scoreboard bench for axi_lite_responder.
// Instance u_a uses defaults; u_b uses DEPTH=64.
module tb_axi_lite_responder;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic [1:0]  a_bresp, a_rresp;
  logic [31:0] a_rdata;
  logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]  b_bresp, b_rresp;
  logic [31:0] b_rdata;

  logic        sel;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  assign awready = sel ? b_awready : a_awready;
  assign wready  = sel ? b_wready  : a_wready;
  assign bvalid  = sel ? b_bvalid  : a_bvalid;
  assign bresp   = sel ? b_bresp   : a_bresp;
  assign arready = sel ? b_arready : a_arready;
  assign rvalid  = sel ? b_rvalid  : a_rvalid;
  assign rdata   = sel ? b_rdata   : a_rdata;
  assign rresp   = sel ? b_rresp   : a_rresp;

  axi_lite_responder u_a (
    .ACLK(clk), .ARESET(rst),
    .awvalid(awvalid), .awready(a_awready),
    .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(a_wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(a_bvalid), .bready(bready), .bresp(a_bresp),
    .arvalid(arvalid), .arready(a_arready),
    .araddr(araddr), .arprot(arprot),
    .rvalid(a_rvalid), .rready(rready),
    .rdata(a_rdata), .rresp(a_rresp)
  );

  axi_lite_responder #(.DEPTH(64)) u_b (
    .ACLK(clk), .ARESET(rst),
    .awvalid(awvalid), .awready(b_awready),
    .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(b_wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(b_bvalid), .bready(bready), .bresp(b_bresp),
    .arvalid(arvalid), .arready(b_arready),
    .araddr(araddr), .arprot(arprot),
    .rvalid(b_rvalid), .rready(rready),
    .rdata(b_rdata), .rresp(b_rresp)
  );

  int errors = 0;
  int checks = 0;
  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  task automatic send_aw(input logic [11:0] a, input logic [2:0] p);
    int n = 0;
    awvalid = 1'b1; awaddr = a; awprot = p;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wvalid = 1'b1; wdata = d; wstrb = s;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic wait_b(input string name);
    int n = 0;
    logic [1:0] e;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    e = bq.pop_front();
    checks++;
    if (!bvalid) begin
      errors++;
      $display("FAIL %s bvalid timeout: got 0 want 1", name);
    end else if (bresp !== e) begin
      errors++;
      $display("FAIL %s bresp: got %b want %b", name, bresp, e);
    end
    @(negedge clk);
  endtask

  // lead>0: W leads AW by lead cycles; lead<0: AW leads; 0: same cycle
  task automatic do_write(input logic [11:0] a, input logic [2:0] p,
                          input logic [31:0] d, input logic [3:0] s,
                          input int lead, input logic [1:0] resp,
                          input string name);
    bq.push_back(resp);
    bready = 1'b1;
    if (lead == 0) begin
      awvalid = 1'b1; awaddr = a; awprot = p;
      wvalid = 1'b1; wdata = d; wstrb = s;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
    end else if (lead > 0) begin
      send_w(d, s);
      repeat (lead - 1) @(negedge clk);
      send_aw(a, p);
    end else begin
      send_aw(a, p);
      repeat (-lead - 1) @(negedge clk);
      send_w(d, s);
    end
    wait_b(name);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [2:0] p,
                         input logic [31:0] d, input logic [1:0] resp,
                         input string name);
    int n = 0;
    logic [33:0] e;
    rq.push_back({d, resp});
    rready = 1'b1;
    arvalid = 1'b1; araddr = a; arprot = p;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    e = rq.pop_front();
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: rvalid=%b want 1", name, rvalid);
    end else if ({rdata, rresp} !== e) begin
      errors++;
      $display("FAIL %s data/resp: got %h/%b want %h/%b",
               name, rdata, rresp, e[33:2], e[1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if ({arready, awready, wready, rvalid, bvalid,
         rdata, rresp, bresp} !== {3'b111, 2'b00, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b%b%b%b%b %h %b %b want 11100 0 0 0",
               arready, awready, wready, rvalid, bvalid,
               rdata, rresp, bresp);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_read;
    do_read(12'h004, 3'b001, 32'h0, OKAY, "read_after_reset");
  endtask

  task automatic test_strobes;
    do_write(12'h010, 3'b001, 32'hDEADBEEF, 4'b0101, 3, OKAY, "w_first");
    do_read(12'h010, 3'b001, 32'h00AD00EF, OKAY, "rd_strobe");
    do_write(12'h014, 3'b001, 32'h12345678, 4'b1111, -2, OKAY, "aw_first");
    do_read(12'h014, 3'b001, 32'h12345678, OKAY, "rd_aw_first");
    do_write(12'h018, 3'b001, 32'hAABBCCDD, 4'b1010, 0, OKAY, "same_cyc");
    do_read(12'h018, 3'b001, 32'hAA00CC00, OKAY, "rd_same_cyc");
    do_read(12'hC10, 3'b001, 32'h00AD00EF, OKAY, "rd_slave_sel");
    do_write(12'h011, 3'b001, 32'hFFFFFFFF, 4'hF, 0, SLVERR, "w_misalign");
    do_read(12'h010, 3'b001, 32'h00AD00EF, OKAY, "rd_unchanged");
  endtask

  task automatic test_priv;
    do_read(12'h3FC, 3'b000, 32'h0, SLVERR, "priv_rd_user");
    do_read(12'h3FC, 3'b001, 32'h0, OKAY, "priv_rd_priv");
    do_read(12'h2FC, 3'b000, 32'h0, OKAY, "below_priv");
    do_write(12'h300, 3'b000, 32'h55555555, 4'hF, 0, SLVERR, "priv_w_user");
    do_read(12'h300, 3'b001, 32'h0, OKAY, "priv_unchanged");
    do_write(12'h300, 3'b001, 32'h55555555, 4'hF, 1, OKAY, "priv_w_priv");
    do_read(12'h300, 3'b001, 32'h55555555, OKAY, "priv_readback");
  endtask

  task automatic test_depth64;
    sel = 1'b1;
    do_read(12'h100, 3'b001, 32'h0, DECERR, "d64_decerr");
    do_read(12'h006, 3'b001, 32'h0, SLVERR, "d64_misalign");
    do_write(12'h0FC, 3'b001, 32'hCAFEF00D, 4'hF, 0, OKAY, "d64_w_last");
    do_write(12'h0FD, 3'b001, 32'h0, 4'hF, 0, SLVERR, "d64_w_mis");
    do_write(12'h101, 3'b001, 32'h0, 4'hF, 0, SLVERR, "d64_w_101");
    do_read(12'h0FC, 3'b000, 32'hCAFEF00D, OKAY, "d64_unchanged");
    sel = 1'b0;
  endtask

  task automatic test_stall;
    int n = 0;
    logic [33:0] e;
    logic [1:0] eb;
    rq.push_back({32'h00AD00EF, OKAY});
    rready = 1'b0;
    arvalid = 1'b1; araddr = 12'h010; arprot = 3'b001;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    e = rq.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, arready, rdata, rresp} !== {2'b10, e}) begin
        errors++;
        $display("FAIL r_stall cyc%0d: got %b%b %h %b want 10 %h %b",
                 i, rvalid, arready, rdata, rresp, e[33:2], e[1:0]);
      end
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++;
      $display("FAIL r_release: got %b%b want 01", rvalid, arready);
    end
    bq.push_back(OKAY);
    bready = 1'b0;
    awvalid = 1'b1; awaddr = 12'h024; awprot = 3'b001;
    wvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    eb = bq.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== {1'b1, eb, 2'b00}) begin
        errors++;
        $display("FAIL b_stall cyc%0d: got %b %b %b%b want 1 %b 00",
                 i, bvalid, bresp, awready, wready, eb);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++;
      $display("FAIL b_release: got %b%b%b want 011",
               bvalid, awready, wready);
    end
  endtask

  task automatic test_same_cycle;
    logic [33:0] e;
    logic [1:0] eb;
    do_write(12'h020, 3'b001, 32'h11111111, 4'hF, 0, OKAY, "pre_w");
    bq.push_back(OKAY);
    rq.push_back({32'h11111111, OKAY});
    bready = 1'b1; rready = 1'b1;
    awvalid = 1'b1; awaddr = 12'h020; awprot = 3'b001;
    wvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 12'h020; arprot = 3'b001;
    @(negedge clk);
    arvalid = 1'b0;
    e = rq.pop_front();
    eb = bq.pop_front();
    checks++;
    if ({rvalid, rdata, rresp} !== {1'b1, e}) begin
      errors++;
      $display("FAIL rw_collide read: got %b %h %b want 1 %h %b",
               rvalid, rdata, rresp, e[33:2], e[1:0]);
    end
    checks++;
    if ({bvalid, bresp} !== {1'b1, eb}) begin
      errors++;
      $display("FAIL rw_collide bresp: got %b %b want 1 %b",
               bvalid, bresp, eb);
    end
    @(negedge clk);
    do_read(12'h020, 3'b001, 32'h22222222, OKAY, "rw_collide_later");
  endtask

  task automatic test_reset_mid;
    rready = 1'b0;
    arvalid = 1'b1; araddr = 12'h010; arprot = 3'b001;
    @(negedge clk);
    arvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_rst read: got %b%b want 01", rvalid, arready);
    end
    @(negedge clk);
    rst = 1'b0;
    rready = 1'b1;
    bready = 1'b1;
    send_aw(12'h040, 3'b001);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_w(32'h0BADF00D, 4'hF);
    repeat (4) @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst aw_dropped: bvalid=%b want 0", bvalid);
    end
    bq.push_back(OKAY);
    send_aw(12'h040, 3'b001);
    wait_b("mid_rst_commit");
    do_read(12'h040, 3'b001, 32'h0BADF00D, OKAY, "mid_rst_held_w");
    do_read(12'h010, 3'b001, 32'h0, OKAY, "mem_cleared");
  endtask

  initial begin
    sel = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    wdata = '0; wstrb = '0;
    test_reset();
    test_basic_read();
    test_strobes();
    test_priv();
    test_depth64();
    test_stall();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
